// File: rtl/monitor_maquina.sv
// -----------------------------------------------------------------------------
// monitor_maquina
// Passive checker for the coffee-machine controller state bus. Every rising
// edge it judges the step (prev_state, prev_start) -> state against the legal
// brew sequence, keeps its own model of the reservoir-full flag, counts
// completed coffees and measures the length of each brew.
//
// Parameters:
//   CNT_W  width of the completed-coffee counter (saturating)
//   LAT_W  width of the brew-length counter / result (saturating)
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset, shared with the controller
//   start        start request, as seen by the controller
//   state[3:0]   controller state bus
//   clr_erro     synchronous clear of erro / erro_code
//   cafe_pronto  one-cycle pulse per completed brew
//   cafe_count   completed brews, saturating
//   brew_cycles  length of the last completed brew in cycles, saturating
//   erro         sticky error flag
//   erro_code    first error cause: 0 none, 1 illegal encoding, 2 illegal step
//   agua_model   monitor's model of the reservoir-full flag
// -----------------------------------------------------------------------------
module monitor_maquina #(
    parameter int CNT_W = 8,
    parameter int LAT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       state,
    input  logic             clr_erro,
    output logic             cafe_pronto,
    output logic [CNT_W-1:0] cafe_count,
    output logic [LAT_W-1:0] brew_cycles,
    output logic             erro,
    output logic [1:0]       erro_code,
    output logic             agua_model
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd1,
        S_LIGAR     = 4'd2,
        S_VERIFICAR = 4'd3,
        S_ENCHER    = 4'd4,
        S_MOER      = 4'd5,
        S_COLOCAR   = 4'd6,
        S_PASSAR    = 4'd7,
        S_TAMPEAR   = 4'd8,
        S_EXTRACAO  = 4'd9
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    logic [3:0]       prev_state_q, prev_state_d;
    logic             prev_start_q, prev_start_d;
    logic [LAT_W-1:0] run_q, run_d;
    logic             brewing_q, brewing_d;
    logic             cafe_pronto_q, cafe_pronto_d;
    logic [CNT_W-1:0] cafe_count_q, cafe_count_d;
    logic [LAT_W-1:0] brew_cycles_q, brew_cycles_d;
    logic             erro_q, erro_d;
    logic [1:0]       erro_code_q, erro_code_d;
    logic             agua_q, agua_d;

    logic             enc_bad_s;
    logic             legal_s;
    logic             err_s;
    logic [1:0]       new_code_s;

    // Transition legality, error latching, refill model and brew measurement.
    always_comb begin
        prev_state_d  = state;
        prev_start_d  = start;
        run_d         = run_q;
        brewing_d     = brewing_q;
        cafe_pronto_d = 1'b0;
        cafe_count_d  = cafe_count_q;
        brew_cycles_d = brew_cycles_q;
        erro_d        = erro_q;
        erro_code_d   = erro_code_q;
        agua_d        = agua_q;

        enc_bad_s = (state == 4'd0) || (state > 4'd9);

        case (prev_state_q)
            S_IDLE:      legal_s = prev_start_q ? (state == S_LIGAR) : (state == S_IDLE);
            S_LIGAR:     legal_s = (state == S_VERIFICAR);
            S_VERIFICAR: legal_s = agua_q ? (state == S_MOER) : (state == S_ENCHER);
            S_ENCHER:    legal_s = (state == S_VERIFICAR);
            S_MOER:      legal_s = (state == S_COLOCAR);
            S_COLOCAR:   legal_s = (state == S_PASSAR);
            S_PASSAR:    legal_s = (state == S_TAMPEAR);
            S_TAMPEAR:   legal_s = (state == S_EXTRACAO);
            S_EXTRACAO:  legal_s = (state == S_IDLE);
            // Previous sample was itself an illegal encoding (already flagged):
            // accept whatever follows and resume checking from it.
            default:     legal_s = 1'b1;
        endcase

        err_s      = enc_bad_s || !legal_s;
        new_code_s = enc_bad_s ? 2'd1 : 2'd2;

        // A new error beats a simultaneous clear; otherwise the first cause sticks.
        if (err_s) begin
            erro_d = 1'b1;
            if (!erro_q || clr_erro) begin
                erro_code_d = new_code_s;
            end else begin
                erro_code_d = erro_code_q;
            end
        end else if (clr_erro) begin
            erro_d      = 1'b0;
            erro_code_d = 2'd0;
        end else begin
            erro_d      = erro_q;
            erro_code_d = erro_code_q;
        end

        // The only step that refills the reservoir.
        if (!err_s && (prev_state_q == S_ENCHER) && (state == S_VERIFICAR)) begin
            agua_d = 1'b1;
        end else begin
            agua_d = agua_q;
        end

        if (!err_s && (prev_state_q == S_IDLE) && (state == S_LIGAR)) begin
            brewing_d = 1'b1;
            run_d     = LAT_ONE;
        end else if (brewing_q) begin
            if (err_s) begin
                brewing_d = 1'b0;
            end else if ((prev_state_q == S_EXTRACAO) && (state == S_IDLE)) begin
                brewing_d     = 1'b0;
                brew_cycles_d = run_q;
                cafe_pronto_d = 1'b1;
                cafe_count_d  = (cafe_count_q == CNT_MAX) ? CNT_MAX : cafe_count_q + CNT_ONE;
            end else if (state != S_IDLE) begin
                run_d = (run_q == LAT_MAX) ? LAT_MAX : run_q + LAT_ONE;
            end else begin
                run_d = run_q;
            end
        end else begin
            brewing_d = brewing_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_q  <= S_IDLE;
            prev_start_q  <= 1'b0;
            run_q         <= {LAT_W{1'b0}};
            brewing_q     <= 1'b0;
            cafe_pronto_q <= 1'b0;
            cafe_count_q  <= {CNT_W{1'b0}};
            brew_cycles_q <= {LAT_W{1'b0}};
            erro_q        <= 1'b0;
            erro_code_q   <= 2'd0;
            agua_q        <= 1'b0;
        end else begin
            prev_state_q  <= prev_state_d;
            prev_start_q  <= prev_start_d;
            run_q         <= run_d;
            brewing_q     <= brewing_d;
            cafe_pronto_q <= cafe_pronto_d;
            cafe_count_q  <= cafe_count_d;
            brew_cycles_q <= brew_cycles_d;
            erro_q        <= erro_d;
            erro_code_q   <= erro_code_d;
            agua_q        <= agua_d;
        end
    end

    assign cafe_pronto = cafe_pronto_q;
    assign cafe_count  = cafe_count_q;
    assign brew_cycles = brew_cycles_q;
    assign erro        = erro_q;
    assign erro_code   = erro_code_q;
    assign agua_model  = agua_q;

endmodule

// File: tb/tb_monitor_maquina.sv
// -----------------------------------------------------------------------------
// Bench for monitor_maquina: a table of directed steps with explicit expected
// outputs, hand-written brew / reset sequences, then randomized traffic, all
// compared every cycle against a behavioural model of the legal brew recipe.
// A second instance with CNT_W=2 shares the stimulus to observe saturation.
// -----------------------------------------------------------------------------
module tb_monitor_maquina;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] state;
    logic       clr_erro;

    logic       pronto, erro, agua;
    logic [7:0] count;
    logic [4:0] cycles;
    logic [1:0] code;

    logic       pronto2, erro2, agua2;
    logic [1:0] count2;
    logic [4:0] cycles2;
    logic [1:0] code2;

    monitor_maquina dut (
        .clk(clk), .rst_n(rst_n), .start(start), .state(state), .clr_erro(clr_erro),
        .cafe_pronto(pronto), .cafe_count(count), .brew_cycles(cycles),
        .erro(erro), .erro_code(code), .agua_model(agua)
    );

    monitor_maquina #(.CNT_W(2), .LAT_W(5)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .start(start), .state(state), .clr_erro(clr_erro),
        .cafe_pronto(pronto2), .cafe_count(count2), .brew_cycles(cycles2),
        .erro(erro2), .erro_code(code2), .agua_model(agua2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int p2_pulses = 0;

    // Reference model: recipe-level bookkeeping in plain integers.
    int m_prev, m_pstart, m_agua, m_brewing, m_run, m_brews, m_cycles, m_erro, m_code, m_pronto;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Next step of the recipe from a legal state.
    function automatic int succ(input int prev, input int ps, input int ag);
        if (prev == 1) return ps ? 2 : 1;
        if (prev == 3) return ag ? 5 : 4;
        if (prev == 4) return 3;
        if (prev == 9) return 1;
        if (prev >= 2 && prev <= 8) return prev + 1;
        return 1;
    endfunction

    task automatic model_reset();
        m_prev = 1; m_pstart = 0; m_agua = 0; m_brewing = 0; m_run = 0;
        m_brews = 0; m_cycles = 0; m_erro = 0; m_code = 0; m_pronto = 0;
    endtask

    task automatic model_step(input int st, input int s, input int c);
        int enc_bad, tr_bad, cause;
        enc_bad = (s == 0 || s > 9);
        tr_bad  = !enc_bad && (m_prev >= 1 && m_prev <= 9) && (s != succ(m_prev, m_pstart, m_agua));
        cause   = enc_bad ? 1 : (tr_bad ? 2 : 0);
        m_pronto = 0;
        if (cause != 0) begin
            if (!m_erro || c) m_code = cause;
            m_erro = 1;
        end else if (c) begin
            m_erro = 0; m_code = 0;
        end
        if (cause == 0 && m_prev == 4 && s == 3) m_agua = 1;
        if (cause == 0 && m_prev == 1 && s == 2) begin
            m_brewing = 1; m_run = 1;
        end else if (m_brewing) begin
            if (cause != 0) m_brewing = 0;
            else if (s == 1) begin
                m_cycles = m_run; m_pronto = 1; m_brews++; m_brewing = 0;
            end else m_run = (m_run + 1 > 31) ? 31 : m_run + 1;
        end
        m_prev = s;
        m_pstart = st;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_pronto"}, pronto, m_pronto);
        chk({tag, "_count"},  count,  (m_brews > 255) ? 255 : m_brews);
        chk({tag, "_cycles"}, cycles, m_cycles);
        chk({tag, "_erro"},   erro,   m_erro);
        chk({tag, "_code"},   code,   m_code);
        chk({tag, "_agua"},   agua,   m_agua);
        chk({tag, "_pronto2"}, pronto2, m_pronto);
        chk({tag, "_count2"},  count2,  (m_brews > 3) ? 3 : m_brews);
    endtask

    task automatic step(input int st, input int s, input int c);
        start = st[0]; state = s[3:0]; clr_erro = c[0];
        @(posedge clk); #1;
        if (pronto2) p2_pulses++;
        model_step(st, s, c);
        compare_all("model");
    endtask

    task automatic brew(input int refill);
        step(1, 1, 0);
        step(0, 2, 0);
        step(0, 3, 0);
        if (refill) begin
            step(0, 4, 0);
            step(0, 3, 0);
        end
        for (int k = 5; k <= 9; k++) step(0, k, 0);
        step(0, 1, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pronto"}, pronto, 0);
        chk({tag, "_count"},  count,  0);
        chk({tag, "_cycles"}, cycles, 0);
        chk({tag, "_erro"},   erro,   0);
        chk({tag, "_code"},   code,   0);
        chk({tag, "_agua"},   agua,   0);
        chk({tag, "_count2"}, count2, 0);
    endtask

    typedef struct {
        int st; int s; int c;
        int p; int cnt; int cyc; int e; int cd; int a;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int st, int s, int c, int p, int cnt, int cyc, int e, int cd, int a);
        vec_t v;
        v.st = st; v.s = s; v.c = c; v.p = p; v.cnt = cnt; v.cyc = cyc; v.e = e; v.cd = cd; v.a = a;
        return v;
    endfunction

    initial begin
        // brew 1 with refill
        tbl.push_back(mk(1,1,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,2,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,3,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,4,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,3,0, 0,0,0,0,0,1));
        for (int k = 5; k <= 9; k++) tbl.push_back(mk(0,k,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,1,0, 1,1,9,0,0,1));
        // brew 2 without refill
        tbl.push_back(mk(1,1,0, 0,1,9,0,0,1));
        tbl.push_back(mk(0,2,0, 0,1,9,0,0,1));
        tbl.push_back(mk(0,3,0, 0,1,9,0,0,1));
        for (int k = 5; k <= 9; k++) tbl.push_back(mk(0,k,0, 0,1,9,0,0,1));
        tbl.push_back(mk(0,1,0, 1,2,7,0,0,1));
        // illegal encoding during MOER
        tbl.push_back(mk(1,1,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,2,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,3,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,5,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,0,0, 0,2,7,1,1,1));
        for (int k = 6; k <= 9; k++) tbl.push_back(mk(0,k,0, 0,2,7,1,1,1));
        tbl.push_back(mk(0,1,0, 0,2,7,1,1,1));
        // clear, then 3->6 and 5->5: first cause (2) sticks
        tbl.push_back(mk(0,1,1, 0,2,7,0,0,1));
        tbl.push_back(mk(1,1,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,2,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,3,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,6,0, 0,2,7,1,2,1));
        tbl.push_back(mk(0,5,0, 0,2,7,1,2,1));
        tbl.push_back(mk(0,5,0, 0,2,7,1,2,1));
        tbl.push_back(mk(0,6,1, 0,2,7,0,0,1));
        for (int k = 7; k <= 9; k++) tbl.push_back(mk(0,k,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,1,0, 0,2,7,0,0,1));
        // clear together with a new error: error wins
        tbl.push_back(mk(0,2,1, 0,2,7,1,2,1));
        tbl.push_back(mk(0,3,1, 0,2,7,0,0,1));
        for (int k = 5; k <= 9; k++) tbl.push_back(mk(0,k,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,1,0, 0,2,7,0,0,1));
        // IDLE held while start was seen
        tbl.push_back(mk(1,1,0, 0,2,7,0,0,1));
        tbl.push_back(mk(0,1,0, 0,2,7,1,2,1));
        tbl.push_back(mk(0,1,1, 0,2,7,0,0,1));

        rst_n = 1'b0; start = 1'b0; state = 4'd1; clr_erro = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].s, tbl[i].c);
            chk($sformatf("v%0d_pronto", i), pronto, tbl[i].p);
            chk($sformatf("v%0d_count", i),  count,  tbl[i].cnt);
            chk($sformatf("v%0d_cycles", i), cycles, tbl[i].cyc);
            chk($sformatf("v%0d_erro", i),   erro,   tbl[i].e);
            chk($sformatf("v%0d_code", i),   code,   tbl[i].cd);
            chk($sformatf("v%0d_agua", i),   agua,   tbl[i].a);
        end

        // narrow counter saturates at 3 after the fourth brew
        brew(0);
        brew(0);
        chk("sat_count2_4", count2, 3);
        chk("sat_pulses_4", p2_pulses, 4);
        brew(0);
        chk("sat_count2_5", count2, 3);
        chk("sat_pulses_5", p2_pulses, 5);
        chk("sat_count_5", count, 5);
        chk("sat_cycles", cycles, 7);

        // reset during PASSAR, then the next brew must refill
        step(1, 1, 0);
        step(0, 2, 0);
        step(0, 3, 0);
        step(0, 5, 0);
        step(0, 6, 0);
        step(0, 7, 0);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        brew(1);
        chk("refill_cycles", cycles, 9);
        chk("refill_count", count, 1);
        chk("refill_agua", agua, 1);
        chk("refill_erro", erro, 0);

        // randomized traffic: mostly legal recipe steps, some corruption
        for (int n = 0; n < 800; n++) begin
            int s_nxt, st_nxt, c_nxt;
            if ($urandom_range(0, 19) == 0) s_nxt = $urandom_range(0, 15);
            else s_nxt = succ(m_prev, m_pstart, m_agua);
            st_nxt = ($urandom_range(0, 3) == 0) ? 1 : 0;
            c_nxt  = ($urandom_range(0, 15) == 0) ? 1 : 0;
            step(st_nxt, s_nxt, c_nxt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/monitor_maquina.md
Name: monitor_maquina

Overview:
- Passive observer and checker for the coffee-machine controller's state bus. It is the consumer end of the `start`/`state` interface.
- Samples `start` and `state[3:0]` each clock and checks every transition against the legal sequence, using its own model of the water-reservoir flag.
- Counts completed coffees and measures the length of each brew.
- Sits beside the controller on the same clk/rst_n; drives nothing back into it.

Parameters:
- CNT_W, 8: width of the completed-coffee counter; saturates at 2^CNT_W-1.
- LAT_W, 5: width of the brew-length counter and result; saturates at 2^LAT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset; shared with the controller.
- start  in  1  same start signal the controller sees.
- state  in  4  controller state bus.
  - Encodings: 1 IDLE, 2 LIGAR, 3 VERIFICAR, 4 ENCHER, 5 MOER, 6 COLOCAR, 7 PASSAR, 8 TAMPEAR, 9 EXTRACAO.
- clr_erro  in  1  synchronous clear of erro/erro_code.
- cafe_pronto  out  1  one-cycle pulse per completed brew.
- cafe_count  out  CNT_W  completed brews, saturating.
- brew_cycles  out  LAT_W  length of the last completed brew in cycles, saturating.
- erro  out  1  sticky error flag.
- erro_code  out  2  first error cause: 0 none, 1 illegal encoding, 2 illegal transition.
- agua_model  out  1  monitor's model of the reservoir-full flag.

Behaviour:
- Reset values (async while rst_n=0):
  - Outputs: all outputs 0.
  - Internal: prev_state=IDLE, prev_start=0, run counter 0, brewing=0.
- Each rising edge, the monitor evaluates the pair (prev_state, prev_start) -> state, where state is the value sampled at this edge.
- All outputs are registered and update on that same edge. prev_state<=state and prev_start<=start every cycle.
- Legal transitions:
  - IDLE->IDLE if !prev_start.
  - IDLE->LIGAR if prev_start.
  - LIGAR->VERIFICAR.
  - VERIFICAR->ENCHER if !agua_model.
  - VERIFICAR->MOER if agua_model.
  - ENCHER->VERIFICAR; this sets agua_model=1 at the same edge.
  - MOER->COLOCAR->PASSAR->TAMPEAR->EXTRACAO->IDLE.
- Error detection:
  - Sampled state of 0 or 10..15 -> error code 1. This takes priority over the transition check.
  - Any other mismatch against the legal transitions -> error code 2. This includes a non-IDLE state held for 2 or more samples, and IDLE held while prev_start=1.
- Error latching:
  - On an error: erro<=1. erro_code is loaded only if erro was 0; the first error wins.
  - Same cycle as clr_erro and a new error: the new error wins (erro=1, code = new cause).
  - clr_erro with no new error: erro<=0, erro_code<=0.
- Resynchronisation: after any error the monitor simply carries on, checking from the observed state. No stall, no reset of counters. agua_model is unchanged.
- Brew measurement:
  - On a legal IDLE->LIGAR: brewing<=1, run counter<=1.
  - Each subsequent sampled non-IDLE state while brewing: run counter +1, saturating.
  - On EXTRACAO->IDLE while brewing:
    - brew_cycles<=run counter.
    - cafe_pronto<=1 for exactly one cycle.
    - cafe_count +1, saturating at 2^CNT_W-1.
    - brewing<=0.
  - An error while brewing clears brewing. No cafe_pronto is produced for that brew, and brew_cycles keeps its old value.
- Expected brew lengths: first brew after reset = 9 (includes the refill); later brews = 7.
- cafe_pronto defaults to 0 on every cycle where the completion condition is not met.
- Reset mid-brew: immediate return to the reset values. agua_model=0, so the next brew must refill.

Test Plan:
- Reset, start=1 for one cycle, controller sequence 2,3,4,3,5,6,7,8,9,1 -> one cafe_pronto pulse on the IDLE sample; cafe_count=1, brew_cycles=9, agua_model=1, erro=0.
- Second start, sequence 2,3,5,6,7,8,9,1 -> cafe_count=2, brew_cycles=7, erro=0.
- Force state=0 for one cycle during MOER -> erro=1, erro_code=1, no cafe_pronto for that brew, brew_cycles still 7.
- With agua_model=1, drive 3->6, then 5->5 -> erro_code stays 2 (first error wins). Pulse clr_erro -> erro=0, erro_code=0 next cycle.
- CNT_W=2, four legal brews -> cafe_count reaches 3 and holds at 3; four cafe_pronto pulses seen.
- Assert rst_n=0 during PASSAR -> all outputs 0 immediately. The next legal brew must include ENCHER, and brew_cycles=9.
